// File: rtl/johnson_updown_counter_ctrl.sv
// Johnson (twisted-ring) up/down counter with checked load, illegal-state recovery,
// wrap/saturate modes, terminal count and a registered binary ring index.
module johnson_updown_counter_ctrl #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [IDX_W-1:0] index,
  output logic             tc,
  output logic             err,
  output logic             err_sticky
);

  localparam logic [WIDTH-1:0] RESET_PAT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2 * WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // A ring pattern is legal when adjacent bits differ at most once.
  function automatic logic is_legal(input logic [WIDTH-1:0] p);
    int trans;
    trans = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans += int'(p[i] ^ p[i+1]);
    end
    return (trans <= 1);
  endfunction

  // Position of a legal pattern: MSB set -> (ones - 1), MSB clear -> (W - 1 + zeros).
  function automatic logic [IDX_W-1:0] decode_idx(input logic [WIDTH-1:0] p);
    int ones;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones += int'(p[i]);
    end
    if (p[WIDTH-1]) begin
      return IDX_W'(ones - 1);
    end else begin
      return IDX_W'(WIDTH - 1 + (WIDTH - ones));
    end
  endfunction

  logic [WIDTH-1:0] count_r, count_nx_s;
  logic [IDX_W-1:0] index_r, index_nx_s;
  logic             err_r, err_nx_s;
  logic             err_sticky_r, err_sticky_nx_s;
  logic             cur_legal_s;
  logic             at_term_s;

  assign cur_legal_s = is_legal(count_r);
  assign at_term_s   = up_down ? (index_r == IDX_LAST) : (index_r == IDX_ZERO);

  // Next-state selection in priority order: load, corruption recovery, step, hold.
  always_comb begin
    count_nx_s      = count_r;
    index_nx_s      = index_r;
    err_nx_s        = 1'b0;
    err_sticky_nx_s = err_sticky_r;
    if (load) begin
      if (is_legal(load_value)) begin
        count_nx_s = load_value;
        index_nx_s = decode_idx(load_value);
      end else begin
        count_nx_s      = RESET_PAT;
        index_nx_s      = IDX_ZERO;
        err_nx_s        = 1'b1;
        err_sticky_nx_s = 1'b1;
      end
    end else if (!cur_legal_s) begin
      count_nx_s      = RESET_PAT;
      index_nx_s      = IDX_ZERO;
      err_nx_s        = 1'b1;
      err_sticky_nx_s = 1'b1;
    end else if (enable) begin
      if (sat && at_term_s) begin
        count_nx_s = count_r;
        index_nx_s = index_r;
      end else if (up_down) begin
        count_nx_s = {~count_r[0], count_r[WIDTH-1:1]};
        index_nx_s = (index_r == IDX_LAST) ? IDX_ZERO : (index_r + IDX_ONE);
      end else begin
        count_nx_s = {count_r[WIDTH-2:0], ~count_r[WIDTH-1]};
        index_nx_s = (index_r == IDX_ZERO) ? IDX_LAST : (index_r - IDX_ONE);
      end
    end else begin
      count_nx_s = count_r;
      index_nx_s = index_r;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r      <= RESET_PAT;
      index_r      <= IDX_ZERO;
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      count_r      <= count_nx_s;
      index_r      <= index_nx_s;
      err_r        <= err_nx_s;
      err_sticky_r <= err_sticky_nx_s;
    end
  end

  assign count      = count_r;
  assign index      = index_r;
  assign err        = err_r;
  assign err_sticky = err_sticky_r;
  assign tc         = enable & ~load & cur_legal_s & at_term_s;

endmodule

// File: tb/tb_johnson_updown_counter_ctrl.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle,
// a separate monitor pops them and compares against the DUT.
module tb_johnson_updown_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, enable, up_down, sat, load;
  logic [3:0] load_value;
  logic [3:0] count;
  logic [2:0] index;
  logic       tc, err, err_sticky;

  johnson_updown_counter_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down), .sat(sat),
    .load(load), .load_value(load_value), .count(count), .index(index),
    .tc(tc), .err(err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] c;
    logic [2:0] i;
    logic       e;
    logic       s;
    logic       t;
  } exp_t;

  exp_t q[$];
  int n_vec  = 0;
  int n_miss = 0;
  bit done   = 1'b0;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s: got %b expected %b", nm, fld, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected response.
  task automatic vec(input string nm, input logic rn, input logic en, input logic ud,
                     input logic st, input logic ld, input logic [3:0] lv,
                     input logic [3:0] ec, input logic [2:0] ei, input logic ee,
                     input logic es, input logic et);
    exp_t r;
    @(negedge clk);
    rst_n = rn; enable = en; up_down = ud; sat = st; load = ld; load_value = lv;
    r.name = nm; r.c = ec; r.i = ei; r.e = ee; r.s = es; r.t = et;
    q.push_back(r);
  endtask

  // Monitor: tc is checked mid-cycle, registered outputs just after the rising edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        r = q.pop_front();
        n_vec++;
        if (r.t !== 1'bx) chk(r.name, "tc", {7'd0, tc}, {7'd0, r.t});
        @(posedge clk);
        #1;
        chk(r.name, "count", {4'd0, count}, {4'd0, r.c});
        chk(r.name, "index", {5'd0, index}, {5'd0, r.i});
        chk(r.name, "err", {7'd0, err}, {7'd0, r.e});
        chk(r.name, "err_sticky", {7'd0, err_sticky}, {7'd0, r.s});
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; up_down = 1'b1; sat = 1'b0; load = 1'b0; load_value = 4'b0000;
    // reset
    vec("rst0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b0, 1'bx);
    vec("rst1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0);
    // count up with wrap
    vec("up1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1100, 3'd1, 1'b0, 1'b0, 1'b0);
    vec("up2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1110, 3'd2, 1'b0, 1'b0, 1'b0);
    vec("up3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 3'd3, 1'b0, 1'b0, 1'b0);
    vec("up4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0111, 3'd4, 1'b0, 1'b0, 1'b0);
    vec("up5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0011, 3'd5, 1'b0, 1'b0, 1'b0);
    vec("up6", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd6, 1'b0, 1'b0, 1'b0);
    vec("up7", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd7, 1'b0, 1'b0, 1'b0);
    vec("upwrap", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b1);
    // count down with wrap
    vec("dnwrap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd7, 1'b0, 1'b0, 1'b1);
    vec("dn6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd6, 1'b0, 1'b0, 1'b0);
    vec("dn5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 3'd5, 1'b0, 1'b0, 1'b0);
    // saturate at top, then reverse
    vec("sat6", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd6, 1'b0, 1'b0, 1'b0);
    vec("sat7", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd7, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      vec("sathold", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd7, 1'b0, 1'b0, 1'b1);
    vec("satrev", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd6, 1'b0, 1'b0, 1'b0);
    // loads: legal, illegal, idle after error pulse
    vec("ld0011", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 4'b0011, 3'd5, 1'b0, 1'b0, 1'b0);
    vec("ld0101", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0);
    vec("idle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b1, 1'b0);
    // corrupt the ring while idle
    vec("seu", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0);
    #1 force dut.count_r = 4'b1010;
    #1 release dut.count_r;
    vec("postseu", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b1, 1'b0);
    // load beats enable
    vec("ldvsen", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1110, 4'b1110, 3'd2, 1'b0, 1'b1, 1'b0);
    vec("ld0000", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd7, 1'b0, 1'b1, 1'b0);
    vec("ld1111", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b1111, 3'd3, 1'b0, 1'b1, 1'b0);
    vec("ru4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0111, 3'd4, 1'b0, 1'b1, 1'b0);
    vec("ru5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0011, 3'd5, 1'b0, 1'b1, 1'b0);
    // mid-count reset clears sticky; restart from index 0
    vec("midrst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0);
    vec("rst_up1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1100, 3'd1, 1'b0, 1'b0, 1'b0);
    // reset pulse between edges must be ignored
    vec("glitch", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1110, 3'd2, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    // saturate at bottom going down
    vec("sd1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1100, 3'd1, 1'b0, 1'b0, 1'b0);
    vec("sd0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0);
    vec("sdhold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b1);
    vec("endidle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/johnson_updown_counter_ctrl.md
Name: johnson_updown_counter_ctrl

Overview:
- Next-generation parameterised Johnson (twisted-ring) up/down counter for the counters library.
- Adds to the basic shift counter:
  - synchronous pattern load with legality checking;
  - continuous illegal-state detection and self-recovery (SEU hardening);
  - wrap or saturate mode;
  - terminal-count flag;
  - a registered binary index of the current ring position.
- Used where a glitch-free one-hot-ish sequencer must also report its position to binary control logic.

Parameters:
- WIDTH, 4, ring width in bits; legal range >= 2; sequence length 2*WIDTH.
- IDX_W (localparam), $clog2(2*WIDTH), width of index output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- enable  input  1  advance one step this cycle.
- up_down  input  1  1 = up, 0 = down.
- sat  input  1  1 = saturate at terminal, 0 = wrap.
- load  input  1  load load_value this cycle.
- load_value  input  WIDTH  raw ring pattern to load.
- count  output  WIDTH  ring register.
- index  output  IDX_W  registered binary position of count, 0..2*WIDTH-1.
- tc  output  1  terminal count (combinational).
- err  output  1  one-cycle pulse, illegal pattern detected.
- err_sticky  output  1  set on any err, cleared only by reset.

Behaviour:
- Reset (rst_n low at clk edge): count = {1'b1, (WIDTH-1){0}}; index = 0; err = 0; err_sticky = 0. Reset overrides all other inputs.
- Up step: count <= {~count[0], count[WIDTH-1:1]}; index <= index+1, wrapping 2W-1 -> 0.
- Down step: count <= {count[WIDTH-2:0], ~count[WIDTH-1]}; index <= index-1, wrapping 0 -> 2W-1. Down is the exact inverse of up.
- Index map:
  - k in 0..W-1: top k+1 bits are 1, the rest 0.
  - k in W..2W-1: top k-W+1 bits are 0, the rest 1.
  - Example, W=4: 1000=0, 1100=1, 1110=2, 1111=3, 0111=4, 0011=5, 0001=6, 0000=7.
- Legality: a pattern is legal iff it has at most one bit transition between adjacent bits (forms 1..10..0 or 0..01..1, including all-0 and all-1). There are 2W legal patterns.
- Per-cycle priority when rst_n high:
  1. load:
     - legal load_value: count <= load_value; index <= its decoded position; err <= 0.
     - illegal load_value: count <= reset pattern; index <= 0; err <= 1; err_sticky <= 1.
  2. Else if current count is illegal (corruption): count <= reset pattern; index <= 0; err <= 1; err_sticky <= 1. Applies regardless of enable.
  3. Else if enable:
     - if sat=1 and count is at the terminal for the current direction (index 2W-1 when up, 0 when down): hold count and index;
     - otherwise step.
  4. Else: hold.
- err defaults to 0 on every cycle not listed above, so it is a single-cycle pulse.
- Latency: one clk edge from a sampled enable/load to updated count/index. index is never combinationally derived from count at the output; it is updated in the same edge as count.
- tc = enable & ~load & count legal & ((up_down & index==2W-1) | (~up_down & index==0)). Asserted in both wrap and sat modes.
- Direction change mid-sequence: takes effect on the next step; no extra latency, no skipped state.
- load and enable in the same cycle: load wins, no step.
- Deasserting reset mid-sequence: counting restarts from index 0 on the first enabled edge after release.

Test Plan:
- (WIDTH=4 for all scenarios.)
- Reset, then enable=1, up_down=1, sat=0 for 9 cycles -> count 1000,1100,1110,1111,0111,0011,0001,0000,1000; index 0..7,0; tc high only in the cycle where index=7.
- From index 0 with up_down=0, enable=1, 3 cycles -> count 0000,0001,0011; index 7,6,5; tc high in the first cycle only.
- sat=1, up_down=1, run to index 7, hold enable 3 more cycles -> count stays 0000, index stays 7, tc stays high. Then flip up_down=0 -> next edge count 0001, index 6.
- load=1, load_value=0011 -> next edge count 0011, index 5, err 0. Then load_value=0101 -> count 1000, index 0, err pulses 1 for one cycle, err_sticky=1 until reset.
- Force count=1010 with enable=0 -> next edge count 1000, index 0, err one-cycle pulse. load=1 with enable=1 and legal value -> loaded value appears, no step.
- Assert rst_n=0 for one edge mid-count (index 5) with enable=1 -> count 1000, index 0, err_sticky 0. Confirm a reset asserted between edges has no effect until the next clk edge (synchronous).
